// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the lab ALU datapath: the ALU result width, the result
// type, and the active-low seven-segment patterns for hex digits 0-F
// (segment order {g,f,e,d,c,b,a}, bit 0 = segment a).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 8;

  typedef logic [ALU_W-1:0] result_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage : alu_pkg

// File: rtl/hex_decoder.sv
// -----------------------------------------------------------------------------
// hex_decoder
// Combinational 4-bit to seven-segment decoder, active-low outputs.
//   nibble_i : value 0-F to display
//   seg_o    : segments {g,f,e,d,c,b,a}, 0 = lit
// -----------------------------------------------------------------------------
module hex_decoder
  import alu_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: every case is covered and a default is assigned first, so no latch
    // can be inferred even if the case list is edited later.
    seg_o = SEG_0;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule : hex_decoder

// File: rtl/alu_result_register.sv
// -----------------------------------------------------------------------------
// alu_result_register
// Registered output stage behind the lab ALU. A press of the raw Load_n key
// captures ALUout into entry 0 of a short history; older entries shift down
// and the oldest falls off. The low half of entry 0 feeds back to the ALU as
// operand B. Any history entry can be viewed on two HEX displays.
//
// Ports:
//   Clock      : board clock, rising-edge active
//   Reset_b    : asynchronous active-low reset
//   ALUout     : ALU result, sampled on the capture edge
//   Load_n     : raw active-low key, asynchronous to Clock
//   Hold       : 1 = drop captures
//   HistSel    : history entry to view (0 = current)
//   B          : feedback operand, low half of RegOut
//   RegOut     : current registered result (entry 0)
//   ViewOut    : selected entry, 0 if never written
//   ViewValid  : selected entry written since reset
//   LoadCount  : saturating capture count
//   HEX0/HEX1  : active-low segments for ViewOut[3:0] / ViewOut[7:4]
// -----------------------------------------------------------------------------
module alu_result_register
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                       Clock,
  input  logic                       Reset_b,
  input  logic [WIDTH-1:0]           ALUout,
  input  logic                       Load_n,
  input  logic                       Hold,
  input  logic [$clog2(DEPTH)-1:0]   HistSel,
  output logic [WIDTH/2-1:0]         B,
  output logic [WIDTH-1:0]           RegOut,
  output logic [WIDTH-1:0]           ViewOut,
  output logic                       ViewValid,
  output logic [CNT_W-1:0]           LoadCount,
  output logic [6:0]                 HEX0,
  output logic [6:0]                 HEX1
);

  // ---------------------------------------------------------------------------
  // Key synchronizer and falling-edge detect.
  // All three flops reset to 0 ("pressed"), so a key held down through reset
  // release looks like a continuing press and never produces a pulse; a new
  // capture needs the key to be seen released first.
  // The detected edge is registered once more, so the capture lands on the
  // third edge after the key is first sampled low.
  // ---------------------------------------------------------------------------
  logic s1_q, s2_q, p_q;
  logic load_pulse_q;
  logic capture;

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      p_q          <= 1'b0;
      load_pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its source; blocking here would collapse the chain.
      s1_q         <= Load_n;
      s2_q         <= s1_q;
      p_q          <= s2_q;
      load_pulse_q <= p_q & ~s2_q;
    end
  end

  // Hold is checked only on the single pulse cycle: a held pulse is lost.
  assign capture = load_pulse_q & ~Hold;

  // ---------------------------------------------------------------------------
  // History shift register with per-entry valid bits and capture counter.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [WIDTH-1:0] hist_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    hist_d  = hist_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (capture) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        hist_d[i] = hist_q[i-1];
      end
      hist_d[0] = ALUout;
      valid_d   = {valid_q[DEPTH-2:0], 1'b1};
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      // NOTE: the history is a handful of flops, not a RAM, so it is reset
      // along with everything else; a true memory array would be left unreset.
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // B comes from the register, so the ALU loop is broken by a flop.
  assign RegOut    = hist_q[0];
  assign B         = hist_q[0][WIDTH/2-1:0];
  assign LoadCount = cnt_q;

  // ---------------------------------------------------------------------------
  // View path: combinational from HistSel and state.
  // ---------------------------------------------------------------------------
  always_comb begin
    ViewValid = valid_q[HistSel];
    ViewOut   = '0;
    if (valid_q[HistSel]) begin
      ViewOut = hist_q[HistSel];
    end
  end

  hex_decoder u_hex0 (
    .nibble_i (ViewOut[3:0]),
    .seg_o    (HEX0)
  );

  hex_decoder u_hex1 (
    .nibble_i (ViewOut[7:4]),
    .seg_o    (HEX1)
  );

endmodule : alu_result_register

// File: tb/tb_alu_result_register.sv
// -----------------------------------------------------------------------------
// tb_alu_result_register
// Directed bench for alu_result_register. Expected captures go into a queue
// when a press is driven and are popped when the capture edge is reached;
// a small history model supplies expected view and counter values.
// -----------------------------------------------------------------------------
module tb_alu_result_register;
  import alu_pkg::*;

  logic        Clock;
  logic        Reset_b;
  result_t     ALUout;
  logic        Load_n;
  logic        Hold;
  logic [1:0]  HistSel;
  logic [3:0]  B;
  logic [7:0]  RegOut;
  logic [7:0]  ViewOut;
  logic        ViewValid;
  logic [3:0]  LoadCount;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;

  alu_result_register #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut (
    .Clock     (Clock),
    .Reset_b   (Reset_b),
    .ALUout    (ALUout),
    .Load_n    (Load_n),
    .Hold      (Hold),
    .HistSel   (HistSel),
    .B         (B),
    .RegOut    (RegOut),
    .ViewOut   (ViewOut),
    .ViewValid (ViewValid),
    .LoadCount (LoadCount),
    .HEX0      (HEX0),
    .HEX1      (HEX1)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [7:0] m_hist [4];
  logic [3:0] m_valid;
  logic [3:0] m_cnt;
  logic [7:0] exp_q [$];

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_hist[i] = 8'h00;
    m_valid = 4'b0000;
    m_cnt   = 4'h0;
    exp_q.delete();
  endtask

  task automatic model_capture(input logic [7:0] v);
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = v;
    m_valid   = {m_valid[2:0], 1'b1};
    if (m_cnt != 4'hF) m_cnt = m_cnt + 4'h1;
  endtask

  task automatic apply_reset();
    @(negedge Clock);
    Reset_b = 1'b0;
    model_reset();
    repeat (2) @(negedge Clock);
    Reset_b = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
  endtask

  // Press the key for low_cycles sampled edges (>= 4) and expect one capture
  // exactly on the third edge after the first low sample.
  task automatic press_capture(input string tag, input logic [7:0] v, input int low_cycles);
    logic [7:0] exp_v;
    @(negedge Clock);
    ALUout = v;
    Load_n = 1'b0;
    exp_q.push_back(v);
    repeat (3) @(posedge Clock);   // edges k, k+1, k+2
    #1;
    check({tag, " early"}, RegOut, m_hist[0]);
    @(posedge Clock);              // edge k+3
    #1;
    exp_v = exp_q.pop_front();
    model_capture(exp_v);
    check({tag, " RegOut"}, RegOut, exp_v);
    check({tag, " B"}, B, exp_v[3:0]);
    repeat (low_cycles - 4) @(posedge Clock);
    @(negedge Clock);
    Load_n = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
  endtask

  task automatic check_view(input string tag, input logic [1:0] sel);
    logic [7:0] ev;
    HistSel = sel;
    #1;
    ev = m_valid[sel] ? m_hist[sel] : 8'h00;
    check({tag, " ViewOut"}, ViewOut, ev);
    check({tag, " ViewValid"}, ViewValid, m_valid[sel]);
    check({tag, " HEX0"}, HEX0, seg_ref(ev[3:0]));
    check({tag, " HEX1"}, HEX1, seg_ref(ev[7:4]));
  endtask

  initial begin
    Reset_b = 1'b0;
    ALUout  = 8'h00;
    Load_n  = 1'b1;
    Hold    = 1'b0;
    HistSel = 2'd0;
    model_reset();

    // Reset state
    #12;
    check("rst RegOut", RegOut, 8'h00);
    check("rst B", B, 4'h0);
    check("rst LoadCount", LoadCount, 4'h0);
    check_view("rst", 2'd0);
    check("rst HEX0 zero", HEX0, 7'b1000000);
    @(negedge Clock);
    Reset_b = 1'b1;
    repeat (4) @(posedge Clock);
    #1;

    // 1: single capture, 5-cycle press
    press_capture("t1", 8'hA5, 5);
    check("t1 LoadCount", LoadCount, 4'h1);
    check_view("t1", 2'd0);
    check("t1 HEX1 A", HEX1, 7'b0001000);
    check("t1 HEX0 5", HEX0, 7'b0010010);

    // 2: history shift and eviction
    press_capture("t2a", 8'h11, 4);
    press_capture("t2b", 8'h22, 4);
    press_capture("t2c", 8'h33, 4);
    press_capture("t2d", 8'h44, 4);
    press_capture("t2e", 8'h55, 4);
    for (int s = 0; s < 4; s++) check_view("t2 view", 2'(s));
    HistSel = 2'd3;
    #1;
    check("t2 evicted", ViewOut, 8'h22);
    check("t2 LoadCount", LoadCount, 4'h6);

    // 3: unwritten entry reads zero
    apply_reset();
    press_capture("t3", 8'h3C, 4);
    check_view("t3 sel2", 2'd2);
    check("t3 ViewValid", ViewValid, 1'b0);
    check_view("t3 sel0", 2'd0);

    // 4: Hold drops a press; lowering Hold mid-press does not recover it
    @(negedge Clock);
    Hold   = 1'b1;
    ALUout = 8'hFF;
    Load_n = 1'b0;
    repeat (6) @(posedge Clock);
    #1;
    check("t4 hold RegOut", RegOut, 8'h3C);
    check("t4 hold LoadCount", LoadCount, m_cnt);
    @(negedge Clock);
    Hold = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    check("t4 late RegOut", RegOut, 8'h3C);
    check("t4 late LoadCount", LoadCount, m_cnt);
    @(negedge Clock);
    Load_n = 1'b1;
    repeat (4) @(posedge Clock);
    #1;

    // 5: key held across reset release, then saturation
    @(negedge Clock);
    Load_n  = 1'b0;
    Reset_b = 1'b0;
    model_reset();
    repeat (2) @(negedge Clock);
    Reset_b = 1'b1;
    ALUout  = 8'h66;
    repeat (8) @(posedge Clock);
    #1;
    check("t5 held RegOut", RegOut, 8'h00);
    check("t5 held LoadCount", LoadCount, 4'h0);
    @(negedge Clock);
    Load_n = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
    press_capture("t5 first", 8'h77, 4);
    check("t5 one LoadCount", LoadCount, 4'h1);
    for (int n = 0; n < 16; n++) press_capture("t5 sat", 8'(n * 13), 4);
    check("t5 saturated", LoadCount, 4'hF);

    // 6: asynchronous reset in the middle of a press
    @(negedge Clock);
    ALUout = 8'h99;
    Load_n = 1'b0;
    repeat (2) @(posedge Clock);
    #2;
    Reset_b = 1'b0;
    model_reset();
    #1;
    check("t6 async RegOut", RegOut, 8'h00);
    check("t6 async B", B, 4'h0);
    check("t6 async LoadCount", LoadCount, 4'h0);
    check_view("t6 async", 2'd0);
    @(negedge Clock);
    Reset_b = 1'b1;
    repeat (6) @(posedge Clock);
    #1;
    check("t6 no capture RegOut", RegOut, 8'h00);
    check("t6 no capture LoadCount", LoadCount, 4'h0);
    @(negedge Clock);
    Load_n = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
    check("t6 queue empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_result_register
